// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Optional MDU_CANCEL_EN adds a cancel input that aborts an in-flight operation.
module mult_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
`ifdef MDU_CANCEL_EN
  input  logic            cancel,
`endif
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t            state, state_next;
  logic [2*XLEN-1:0] work, step_next, prod_signed;
  logic [XLEN-1:0]   mcand, a_mag, b_mag, res_hi, res_lo;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [CW-1:0]     cnt;
  logic              neg_q, neg_r, a_neg, b_neg, is_md, is_div, b_zero, last, kill;

`ifdef MDU_CANCEL_EN
  assign kill = cancel && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  // op[2]=0 selects mul/div, op[1] selects divide, op[0]=0 is the signed flavour
  assign is_md  = ~op[2];
  assign is_div = op[1];
  assign a_neg  = ~op[0] & operand_a[XLEN-1];
  assign b_neg  = ~op[0] & operand_b[XLEN-1];
  assign a_mag  = a_neg ? -operand_a : operand_a;
  assign b_mag  = b_neg ? -operand_b : operand_b;
  assign b_zero = (operand_b == '0);
  assign last   = (cnt == CW'(1));
  assign busy   = (state != IDLE);

  // Multiply: work = {partial product, remaining multiplier}; divide: work = {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, mcand} : '0);
    div_shift = {work[2*XLEN-1:XLEN], work[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (state == MUL)
      step_next = {mul_sum, work[XLEN-1:1]};
    else if (div_diff[XLEN])
      step_next = {div_shift[XLEN-1:0], work[XLEN-2:0], 1'b0};
    else
      step_next = {div_diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
    prod_signed = neg_q ? -step_next : step_next;
    if (state == MUL) begin
      res_hi = prod_signed[2*XLEN-1:XLEN];
      res_lo = prod_signed[XLEN-1:0];
    end else begin
      res_hi = neg_r ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
      res_lo = neg_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && is_md) state_next = !is_div ? MUL : (b_zero ? FIN : DIV);
      MUL, DIV: if (last) state_next = IDLE;
      FIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      work        <= '0;
      mcand       <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (is_md) begin
            cnt   <= CW'(XLEN);
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            mcand <= is_div ? b_mag : a_mag;
            // A zero divisor parks the raw dividend in the upper half for HI
            if (is_div && b_zero) work <= {operand_a, {XLEN{1'b0}}};
            else                  work <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
          end else if (op == 3'b100) begin
            hi   <= operand_a;
            done <= 1'b1;
          end else if (op == 3'b101) begin
            lo   <= operand_a;
            done <= 1'b1;
          end
        end
        MUL, DIV: if (!kill) begin
          work <= step_next;
          cnt  <= cnt - CW'(1);
          if (last) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        FIN: if (!kill) begin
          hi          <= work[2*XLEN-1:XLEN];
          lo          <= '1;
          done        <= 1'b1;
          div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: driver tasks push expected {div_by_zero, hi, lo}
// into a queue and a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

  logic        clock, reset_n, start;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b, hi, lo;
  logic        busy, done, div_by_zero;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  logic [64:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  mult_div_unit #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", {div_by_zero, hi, lo}, 65'h0);
      else check("result", {div_by_zero, hi, lo}, exp_q.pop_front());
    end else if (div_by_zero === 1'b1) begin
      check("dbz_without_done", 65'h1, 65'h0);
    end
  end

  // mode: 0 plain, 1 extra start at busy cycle 'at', 2 reset at 'at', 3 cancel at 'at'
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input int eb, input int mode, input int at, input string name);
    int n;
    int held_bad;
    logic [31:0] h0, l0;
    if (mode < 2) exp_q.push_back({ed, eh, el});
    h0 = hi; l0 = lo; held_bad = 0;
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (hi !== h0 || lo !== l0) held_bad++;
      if (n == at) begin
        case (mode)
          1: begin start = 1'b1; op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd3; end
          2: reset_n = 1'b0;
`ifdef MDU_CANCEL_EN
          3: cancel = 1'b1;
`endif
          default: ;
        endcase
      end else begin
        operand_a = $urandom;
        operand_b = $urandom;
      end
      @(negedge clock);
      start = 1'b0; reset_n = 1'b1;
`ifdef MDU_CANCEL_EN
      cancel = 1'b0;
`endif
    end
    check({name, "_busy_cycles"}, 65'(n), 65'(eb));
    if (eb > 0) check({name, "_hilo_held"}, 65'(held_bad), 65'h0);
    if (mode >= 2) check({name, "_hilo_after_abort"}, {1'b0, hi, lo}, {1'b0, eh, el});
    @(negedge clock);
  endtask

  initial begin
    start = 1'b0; op = 3'b000; operand_a = '0; operand_b = '0; reset_n = 1'b0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check("reset_hi", 65'(hi), 65'h0);
    check("reset_lo", 65'(lo), 65'h0);
    check("reset_busy", 65'(busy), 65'h0);
    check("reset_done_dbz", {63'h0, done, div_by_zero}, 65'h0);
    reset_n = 1'b1;

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 32, 0, 0, "multu_max");
    run_op(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0, 32, 0, 0, "mult_neg");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 32, 0, 0, "div_neg_dividend");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 32, 0, 0, "div_overflow");
    run_op(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 32, 0, 0, "div_neg_divisor");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 0, 32, 0, 0, "div_both_neg");
    run_op(OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 0, 32, 0, 0, "divu");
    run_op(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 32, 0, 0, "mult_min_sq");
    run_op(OP_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 0, 32, 0, 0, "multu_carry");
    run_op(OP_DIVU,  32'h64,       32'd0,        32'h00000064, 32'hFFFFFFFF, 1, 1,  0, 0, "divu_zero");
    run_op(OP_MTLO,  32'h12345678, 32'd9,        32'h00000064, 32'h12345678, 0, 0,  0, 0, "mtlo");
    run_op(OP_MTHI,  32'hCAFEBABE, 32'd9,        32'hCAFEBABE, 32'h12345678, 0, 0,  0, 0, "mthi");
    run_op(OP_DIV,   32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1, 1,  0, 0, "div_zero");

    // reserved op: no busy, no done, HI/LO untouched
    @(negedge clock);
    start = 1'b1; op = 3'b110; operand_a = 32'hDEADBEEF; operand_b = 32'h1;
    @(negedge clock);
    start = 1'b0;
    check("reserved_busy", 65'(busy), 65'h0);
    check("reserved_hilo", {1'b0, hi, lo}, {1'b0, 32'h00000005, 32'hFFFFFFFF});
    repeat (3) @(negedge clock);

    run_op(OP_MULTU, 32'd7, 32'd6, 32'h0, 32'd42, 0, 32, 1, 10, "start_while_busy");

    run_op(OP_MTHI, 32'h1, 32'h0, 32'h1, 32'd42, 0, 0, 0, 0, "mthi_1");
    run_op(OP_MTLO, 32'h2, 32'h0, 32'h1, 32'h2,  0, 0, 0, 0, "mtlo_2");
    run_op(OP_DIVU, 32'd1000, 32'd3, 32'h0, 32'h0, 0, 5, 2, 5, "reset_mid_op");
    run_op(OP_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 0, 32, 0, 0, "after_reset");

`ifdef MDU_CANCEL_EN
    run_op(OP_MTHI, 32'hAA, 32'h0, 32'hAA, 32'd12, 0, 0, 0, 0, "mthi_aa");
    run_op(OP_MTLO, 32'hBB, 32'h0, 32'hAA, 32'hBB, 0, 0, 0, 0, "mtlo_bb");
    run_op(OP_MULT, 32'd12345, 32'hFFFFFFFF, 32'hAA, 32'hBB, 0, 20, 3, 20, "cancel_mid_op");
`endif
    run_op(OP_MULT, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 32, 0, 0, "mult_final");

    repeat (3) @(negedge clock);
    check("queue_drained", 65'(exp_q.size()), 65'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
